uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller sitting between the UART receiver core (rx_data/rx_done, shared x16 baud tick) and the APB UART register block. Gates byte capture and buffers received bytes in a small FIFO. Tracks overrun and receive-idle timeout, and produces a single level interrupt for the bus side.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
AW, 3, pointer width; equals log2(DEPTH).
TIMEOUT_TICKS, 640, x16 baud ticks of idle line before timeout fires (640 = 4 character times at 10 bits x 16 ticks).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
tick  in  1  x16 baud tick, one-cycle pulse
rx_done  in  1  one-cycle pulse from receiver core; rx_data valid that cycle
rx_data  in  8  received byte
rx_en  in  1  capture enable from control register
rd_en  in  1  one-cycle pop request from bus side
rd_data  out  8  FIFO head (first-word fall-through)
rx_count  out  AW+1  occupancy, 0..DEPTH
rx_empty  out  1  rx_count == 0
rx_full  out  1  rx_count == DEPTH
thresh  in  AW+1  interrupt threshold; 0 disables threshold interrupt
ovr_clr  in  1  one-cycle clear of overrun flag
ovr_flag  out  1  sticky overrun
timeout_flag  out  1  idle-timeout indication
irq  out  1  level interrupt

Behaviour:
- Reset (rst=0, asynchronous):
  - wptr = rptr = rx_count = 0.
  - ovr_flag = timeout_flag = irq = 0.
  - Timeout FSM in IDLE, tick counter 0.
  - rd_data = 8'h00.
- Write accept (wr_acc): rx_done & rx_en & (!rx_full | rd_en).
  - Stores rx_data at wptr; wptr increments modulo DEPTH.
- Pop accept (rd_acc): rd_en & !rx_empty.
  - rptr increments modulo DEPTH.
  - rd_en while empty is ignored: no pointer or flag change.
- Count update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both in the same cycle: unchanged.
  - Both pointers wrap at DEPTH-1 -> 0.
- Overrun: rx_done & rx_en & rx_full & !rd_en.
  - Byte is dropped and ovr_flag is set.
  - ovr_flag clears only on ovr_clr. If set and clear occur in the same cycle, set wins.
- rx_en=0: rx_done is ignored entirely (no write, no overrun). Deasserting rx_en mid-frame simply drops that frame's rx_done.
- rd_data:
  - Combinational mem[rptr] when !rx_empty; 8'h00 when empty.
  - A newly written byte is visible on rd_data the cycle after wr_acc.
- Timeout FSM, states IDLE / ARMED / FIRED, with counter tcnt (width fits TIMEOUT_TICKS-1).
  - IDLE: tcnt = 0. wr_acc -> ARMED.
  - ARMED:
    - wr_acc clears tcnt.
    - Otherwise tick increments tcnt.
    - tick & tcnt == TIMEOUT_TICKS-1 & !rx_empty -> FIRED, tcnt = 0.
    - FIFO empties (rd_acc leaving count 0 with no wr_acc) -> IDLE.
  - FIRED: timeout_flag = 1 (registered, asserted the cycle after entry).
    - wr_acc -> ARMED, tcnt = 0.
    - rd_acc -> ARMED if count after pop > 0, else IDLE.
    - Either exit clears timeout_flag.
  - Simultaneous wr_acc and timeout expiry: wr_acc wins, stay ARMED, tcnt = 0.
- irq (registered, 1-cycle latency from the causing condition):
  - irq = ((thresh != 0) & (rx_count >= thresh)) | timeout_flag | ovr_flag.

Optional Feature:
UART_RX_CTRL_TIMEOUT_EN
- Defined: timeout FSM and tcnt are present, behaving as above.
- Undefined: FSM and counter are omitted, timeout_flag is tied 0, and irq = threshold term | ovr_flag. The tick port remains but is unused.

Test Plan:
- Reset release, rx_en=1, five rx_done pulses with 8'h11..8'h55 -> rx_count=5, rd_data=8'h11. Five rd_en pops return 11,22,33,44,55. rx_empty=1, rd_data=8'h00.
- Fill 8 bytes (8'hA0..8'hA7) -> rx_full=1. 9th rx_done with 8'hFF -> dropped, ovr_flag=1, irq=1. ovr_clr -> ovr_flag=0. Popping all 8 returns A0..A7, with FF absent.
- Full FIFO, rx_done with 8'hB8 plus rd_en in the same cycle -> A0 popped, B8 written, rx_count stays 8, no overrun. Wrap check: last pop returns B8.
- thresh=4, write 3 bytes -> irq=0. 4th byte -> irq=1 one cycle later. One pop -> irq=0.
- TIMEOUT_EN defined, TIMEOUT_TICKS=640: write 1 byte, then 639 ticks -> timeout_flag=0. 640th tick -> timeout_flag=1, irq=1. rd_en -> timeout_flag=0, FSM IDLE.
- rx_en=0 with rx_done and 8'h5A -> rx_count stays 0, no ovr_flag. Asynchronous rst low with FIFO holding 3 bytes and FSM FIRED -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Purpose:
//   Receive-side controller between the UART receiver core and the APB UART
//   register block. Gates byte capture with rx_en_i and buffers accepted bytes
//   in a first-word-fall-through FIFO. It also tracks a sticky overrun flag and
//   an idle-line receive timeout, and drives one registered level interrupt.
//
// Optional feature macro:
//   UART_RX_CTRL_TIMEOUT_EN - when defined, the idle-timeout FSM and its tick
//   counter are built. When undefined, timeout_flag_o is tied 0, irq_o only
//   reflects the threshold and overrun terms, and tick_i is ignored.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous reset, active low
//   tick_i         x16 baud tick, one-cycle pulse
//   rx_done_i      receiver core byte strobe; rx_data_i is valid this cycle
//   rx_data_i      received byte
//   rx_en_i        capture enable
//   rd_en_i        one-cycle pop request from the bus side
//   rd_data_o      FIFO head, 8'h00 when the FIFO is empty
//   rx_count_o     FIFO occupancy, 0..DEPTH
//   rx_empty_o     occupancy is zero
//   rx_full_o      occupancy is DEPTH
//   thresh_i       interrupt threshold; 0 disables the threshold interrupt
//   ovr_clr_i      one-cycle clear of the overrun flag
//   ovr_flag_o     sticky overrun flag
//   timeout_flag_o idle-timeout indication
//   irq_o          level interrupt
// ----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned AW            = 3,
    parameter int unsigned TIMEOUT_TICKS = 640
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          tick_i,
    input  logic          rx_done_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_en_i,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic [AW:0]   rx_count_o,
    output logic          rx_empty_o,
    output logic          rx_full_o,
    input  logic [AW:0]   thresh_i,
    input  logic          ovr_clr_i,
    output logic          ovr_flag_o,
    output logic          timeout_flag_o,
    output logic          irq_o
);

    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] FullCnt = CW'(DEPTH);

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    logic ovr_q, ovr_d;
    logic irq_q, irq_d;
    logic timeout_flag;

    logic empty, full;
    logic wr_acc, rd_acc;
    logic ovr_set;
    logic thresh_hit;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCnt);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_acc  = rx_done_i & rx_en_i & (~full | rd_en_i);
    assign rd_acc  = rd_en_i & ~empty;
    assign ovr_set = rx_done_i & rx_en_i & full & ~rd_en_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // DEPTH is a power of two, so natural pointer overflow wraps to 0.
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= rx_data_i;
        end
    end

    assign rd_data_o  = empty ? 8'h00 : mem_q[rptr_q];
    assign rx_count_o = count_q;
    assign rx_empty_o = empty;
    assign rx_full_o  = full;

    // ------------------------------------------------------------------------
    // Overrun flag: set has priority over a simultaneous clear.
    // ------------------------------------------------------------------------
    assign ovr_d = ovr_set | (ovr_q & ~ovr_clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr_flag_o = ovr_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Idle-timeout FSM
    // ------------------------------------------------------------------------
    localparam int unsigned TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TW-1:0] TcntLast = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StFired
    } to_state_e;

    to_state_e     state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tflag_q;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            StIdle: begin
                tcnt_d = '0;
                if (wr_acc) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // A new byte restarts the idle window and beats a coincident expiry.
                if (wr_acc) begin
                    tcnt_d = '0;
                end else if (rd_acc && (count_q == CW'(1))) begin
                    state_d = StIdle;
                    tcnt_d  = '0;
                end else if (tick_i) begin
                    if ((tcnt_q == TcntLast) && !empty) begin
                        state_d = StFired;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            StFired: begin
                tcnt_d = '0;
                if (wr_acc) begin
                    state_d = StArmed;
                end else if (rd_acc) begin
                    state_d = (count_q > CW'(1)) ? StArmed : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                tcnt_d  = '0;
            end
        endcase
    end

    // Flag is registered alongside the state so it is high exactly while FIRED.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            tcnt_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            tflag_q <= (state_d == StFired);
        end
    end

    assign timeout_flag = tflag_q;
`else
    logic unused_tick;

    assign unused_tick  = tick_i;
    assign timeout_flag = 1'b0;
`endif

    assign timeout_flag_o = timeout_flag;

    // ------------------------------------------------------------------------
    // Interrupt: registered from the current flag and occupancy state.
    // ------------------------------------------------------------------------
    assign thresh_hit = (thresh_i != '0) && (count_q >= thresh_i);
    assign irq_d      = thresh_hit | timeout_flag | ovr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed testbench for uart_rx_ctrl with DEPTH=8, TIMEOUT_TICKS=640.
// Timeout-specific steps follow UART_RX_CTRL_TIMEOUT_EN so the bench matches
// whichever build of the design it is compiled with.
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       rd_en;
    logic [7:0] rd_data;
    logic [3:0] rx_count;
    logic       rx_empty;
    logic       rx_full;
    logic [3:0] thresh;
    logic       ovr_clr;
    logic       ovr_flag;
    logic       timeout_flag;
    logic       irq;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(
        .DEPTH         (8),
        .AW            (3),
        .TIMEOUT_TICKS (640)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tick_i         (tick),
        .rx_done_i      (rx_done),
        .rx_data_i      (rx_data),
        .rx_en_i        (rx_en),
        .rd_en_i        (rd_en),
        .rd_data_o      (rd_data),
        .rx_count_o     (rx_count),
        .rx_empty_o     (rx_empty),
        .rx_full_o      (rx_full),
        .thresh_i       (thresh),
        .ovr_clr_i      (ovr_clr),
        .ovr_flag_o     (ovr_flag),
        .timeout_flag_o (timeout_flag),
        .irq_o          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        tick    = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        rx_en   = 1'b0;
        rd_en   = 1'b0;
        thresh  = 4'd0;
        ovr_clr = 1'b0;

        // Reset values
        #3;
        chk("rst_count", 32'(rx_count), 0);
        chk("rst_empty", 32'(rx_empty), 1);
        chk("rst_full", 32'(rx_full), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_ovr", 32'(ovr_flag), 0);
        chk("rst_timeout", 32'(timeout_flag), 0);
        chk("rst_irq", 32'(irq), 0);
        #9;
        rst_n = 1'b1;
        rx_en = 1'b1;
        cyc();

        // Five bytes in, five bytes out in order
        for (int i = 1; i <= 5; i++) push(8'(8'h11 * i));
        chk("t1_count", 32'(rx_count), 5);
        chk("t1_head", 32'(rd_data), 32'h11);
        for (int i = 1; i <= 5; i++) begin
            chk("t1_pop_data", 32'(rd_data), 32'h11 * i);
            pop();
        end
        chk("t1_empty", 32'(rx_empty), 1);
        chk("t1_rd_data_empty", 32'(rd_data), 0);
        pop();
        chk("t1_pop_empty_count", 32'(rx_count), 0);

        // Fill, overrun, clear, drain
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
        chk("t2_full", 32'(rx_full), 1);
        chk("t2_count", 32'(rx_count), 8);
        chk("t2_irq_pre", 32'(irq), 0);
        push(8'hFF);
        chk("t2_ovr_set", 32'(ovr_flag), 1);
        chk("t2_count_after_ovr", 32'(rx_count), 8);
        cyc();
        chk("t2_irq_ovr", 32'(irq), 1);
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        chk("t2_ovr_clr", 32'(ovr_flag), 0);
        cyc();
        chk("t2_irq_clr", 32'(irq), 0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_pop_data", 32'(rd_data), 32'hA0 + i);
            pop();
        end
        chk("t2_drained", 32'(rx_empty), 1);

        // Full FIFO with simultaneous write and pop, then wrap
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
        rd_en = 1'b1;
        push(8'hB8);
        rd_en = 1'b0;
        chk("t3_count", 32'(rx_count), 8);
        chk("t3_no_ovr", 32'(ovr_flag), 0);
        chk("t3_head", 32'(rd_data), 32'hA1);
        for (int i = 1; i < 8; i++) pop();
        chk("t3_wrap_last", 32'(rd_data), 32'hB8);
        pop();
        chk("t3_empty", 32'(rx_empty), 1);

        // Overrun set beats a coincident clear
        for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
        ovr_clr = 1'b1;
        push(8'hEE);
        ovr_clr = 1'b0;
        chk("t4_set_wins", 32'(ovr_flag), 1);
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        chk("t4_clear", 32'(ovr_flag), 0);
        for (int i = 0; i < 8; i++) pop();
        chk("t4_empty", 32'(rx_empty), 1);
        cyc();

        // Threshold interrupt
        thresh = 4'd4;
        for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
        cyc();
        chk("t5_irq_below", 32'(irq), 0);
        push(8'h33);
        chk("t5_irq_latency", 32'(irq), 0);
        cyc();
        chk("t5_irq_at", 32'(irq), 1);
        pop();
        cyc();
        chk("t5_irq_after_pop", 32'(irq), 0);
        for (int i = 0; i < 3; i++) pop();
        thresh = 4'd0;
        cyc();

        // Idle timeout
        push(8'h42);
        ticks(639);
        chk("t6_no_timeout_639", 32'(timeout_flag), 0);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        ticks(1);
        chk("t6_timeout_640", 32'(timeout_flag), 1);
        cyc();
        chk("t6_irq_timeout", 32'(irq), 1);
        pop();
        chk("t6_timeout_clr", 32'(timeout_flag), 0);
        chk("t6_empty", 32'(rx_empty), 1);
        ticks(700);
        chk("t6_idle_no_refire", 32'(timeout_flag), 0);
`else
        ticks(1);
        chk("t6_timeout_absent", 32'(timeout_flag), 0);
        cyc();
        chk("t6_irq_quiet", 32'(irq), 0);
        pop();
        chk("t6_empty", 32'(rx_empty), 1);
`endif

        // Capture disabled
        rx_en = 1'b0;
        push(8'h5A);
        chk("t7_rx_en_count", 32'(rx_count), 0);
        chk("t7_rx_en_ovr", 32'(ovr_flag), 0);
        rx_en = 1'b1;

        // Asynchronous reset with live state
        thresh = 4'd2;
        for (int i = 0; i < 3; i++) push(8'(8'h61 + i));
`ifdef UART_RX_CTRL_TIMEOUT_EN
        ticks(640);
        chk("t8_fired", 32'(timeout_flag), 1);
`endif
        cyc();
        chk("t8_irq_pre", 32'(irq), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_count", 32'(rx_count), 0);
        chk("t8_empty", 32'(rx_empty), 1);
        chk("t8_rd_data", 32'(rd_data), 0);
        chk("t8_ovr", 32'(ovr_flag), 0);
        chk("t8_timeout", 32'(timeout_flag), 0);
        chk("t8_irq", 32'(irq), 0);
        #2;
        rst_n  = 1'b1;
        thresh = 4'd0;
        cyc();
        push(8'h77);
        chk("t8_post_rst_data", 32'(rd_data), 32'h77);
        chk("t8_post_rst_count", 32'(rx_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
